// File: rtl/shift_sequencer.sv
// Multi-pass sequencer in front of the 16-bit barrel shifter: applies 0..31 shifts in up to 3 passes.
// Optional macro SHIFT_SEQ_CARRY_EN adds the registered out_carry output.
module shift_sequencer #(
    parameter int DATA_W = 16,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_type,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef SHIFT_SEQ_CARRY_EN
    output logic              out_carry,
`endif
    output logic [1:0]        bs_type,
    output logic [3:0]        bs_shift,
    output logic [DATA_W-1:0] bs_data_in,
    input  logic [DATA_W-1:0] bs_data_out
);

    // state | meaning
    // IDLE  | waiting for a request     LO  | pass with amt[3:0]
    // HI1   | first 8-bit pass          HI2 | second 8-bit pass   DONE | result held
    typedef enum logic [2:0] {IDLE, LO, HI1, HI2, DONE} state_t;

    state_t             state;
    logic [DATA_W-1:0]  acc;
    logic [1:0]         typ;
    logic [AMT_W-1:0]   amt;

    always_comb begin
        bs_shift = 4'd0;
        case (state)
            LO:       bs_shift = amt[3:0];
            HI1, HI2: bs_shift = 4'd8;
            default:  bs_shift = 4'd0;
        endcase
    end

    assign bs_type    = typ;
    assign bs_data_in = acc;
    assign out_data   = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            typ       <= 2'b00;
            amt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        acc      <= in_data;
                        typ      <= in_type;
                        amt      <= in_amt;
                        in_ready <= 1'b0;
                        state    <= LO;
                    end
                end
                LO: begin
                    acc <= bs_data_out;
                    if (amt[4]) begin
                        state <= HI1;
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                HI1: begin
                    acc   <= bs_data_out;
                    state <= HI2;
                end
                HI2: begin
                    acc       <= bs_data_out;
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef SHIFT_SEQ_CARRY_EN
    // Carry is the last bit pushed out by each non-zero pass; zero-shift passes leave it alone.
    logic [3:0] lsl_idx;
    logic [3:0] lsr_idx;

    assign lsl_idx = 4'(5'(DATA_W) - {1'b0, bs_shift});
    assign lsr_idx = bs_shift - 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_carry <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            out_carry <= 1'b0;
        end else if (bs_shift != 4'd0) begin
            case (typ)
                2'b00:   out_carry <= acc[lsl_idx];
                2'b01,
                2'b10:   out_carry <= acc[lsr_idx];
                default: out_carry <= bs_data_out[DATA_W-1];
            endcase
        end
    end
`endif

endmodule
